// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-low, bit order gfedcba.
package sseg_pkg;

  typedef enum logic [0:0] {SHOW, BLANK} state_e;

  localparam logic [3:0] ANODES_OFF = 4'b1111;
  localparam logic [6:0] SEG_OFF    = 7'b1111111;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/sseg_scan_controller.sv
// Four-digit common-anode display scanner with inter-digit blanking and
// frame-aligned (tear-free) commit of new display words.
module sseg_scan_controller
  import sseg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned CNT_W        = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic [3:0]  digit_en,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  sseg,
  output logic        frame_start
);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      disp_q, pend_q;
  logic             pend_full_q;
  logic [3:0]       an_q, an_d;
  logic [6:0]       sseg_q, sseg_d;
  logic             frame_start_q;

  logic             boundary;
  logic             accept;
  logic             upper_zero;
  logic             visible;
  logic [3:0]       nibble;
  logic [6:0]       seg_dec;

  assign load_ready = ~pend_full_q & ~reset;
  assign accept     = load_valid & load_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + CNT_W'(1);
    boundary = 1'b0;
    unique case (state_q)
      SHOW: begin
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      end
      BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d  = SHOW;
          cnt_d    = '0;
          idx_d    = idx_q + 2'd1;
          boundary = (idx_q == 2'd3);
        end
      end
      default: begin
        state_d = SHOW;
        cnt_d   = '0;
      end
    endcase
  end

  // A digit is suppressed when it and every digit to its left are zero.
  always_comb begin
    upper_zero = 1'b0;
    unique case (idx_q)
      2'd0: upper_zero = 1'b0;
      2'd1: upper_zero = (disp_q[15:4] == 12'h000);
      2'd2: upper_zero = (disp_q[15:8] == 8'h00);
      2'd3: upper_zero = (disp_q[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
  end

  assign visible = digit_en[idx_q] & ~(lz_en & upper_zero);
  assign nibble  = disp_q[{idx_q, 2'b00} +: 4];

  hex_to_sseg u_dec (
    .hex_i (nibble),
    .seg_o (seg_dec)
  );

  always_comb begin
    an_d   = ANODES_OFF;
    sseg_d = SEG_OFF;
    if (state_q == SHOW && visible) begin
      an_d   = ~(4'b0001 << idx_q);
      sseg_d = seg_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SHOW;
      idx_q         <= 2'd0;
      cnt_q         <= '0;
      disp_q        <= 16'h0000;
      pend_q        <= 16'h0000;
      pend_full_q   <= 1'b0;
      an_q          <= ANODES_OFF;
      sseg_q        <= SEG_OFF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      an_q          <= an_d;
      sseg_q        <= sseg_d;
      frame_start_q <= boundary;
      // Commit and accept are exclusive: accept needs an empty buffer.
      if (boundary && pend_full_q) begin
        disp_q      <= pend_q;
        pend_full_q <= 1'b0;
      end else if (accept) begin
        pend_q      <= load_data;
        pend_full_q <= 1'b1;
      end
    end
  end

  assign an          = an_q;
  assign sseg        = sseg_q;
  assign frame_start = frame_start_q;

endmodule
